// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath controls from the current state. Define CTRL_JUMP_EN for j support.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur_st;
  state_t nxt_st;
  logic   op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= FETCH;
    else        cur_st <= nxt_st;
  end

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
`ifdef CTRL_JUMP_EN
      OP_J:                           op_legal = 1'b1;
`endif
      default:                        op_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt_st = FETCH;
    case (cur_st)
      FETCH:     nxt_st = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt_st = EXECUTE;
          OP_LW, OP_SW: nxt_st = MEM_ADDR;
          OP_BEQ:       nxt_st = BRANCH;
`ifdef CTRL_JUMP_EN
          OP_J:         nxt_st = JUMP;
`endif
          default:      nxt_st = FETCH;
        endcase
      end
      MEM_ADDR:  nxt_st = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt_st = mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    nxt_st = FETCH;
      MEM_WRITE: nxt_st = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt_st = R_WB;
      R_WB:      nxt_st = FETCH;
      BRANCH:    nxt_st = FETCH;
`ifdef CTRL_JUMP_EN
      JUMP:      nxt_st = FETCH;
`endif
      default:   nxt_st = FETCH;
    endcase
  end

  // Controls are decoded from state; rst_n gates them so a reset mid-access
  // drops every write/read strobe at once rather than at the next edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (cur_st)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~op_legal;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
`ifdef CTRL_JUMP_EN
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = cur_st;

endmodule
